bgm_stream_ctrl: RTL and testbench

Streaming front/back-end controller for the `bgm` floating-point update pipeline.
- Accepts operand sets through a valid/ready handshake and launches one set per cycle into the non-stallable `bgm` datapath.
- Tracks in-flight work with a latency-matched token shift register and captures each `Fn_out` into a result FIFO.
- Drains results to a consumer through a valid/ready handshake.
- Credit-based admission guarantees no result is lost, even though the pipeline cannot stall.

---
 rtl/bgm_pkg.sv | 28 ++
 rtl/bgm_result_fifo.sv | 74 +++++++
 rtl/bgm_stream_ctrl.sv | 131 +++++++++++++
 tb/tb_bgm_stream_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bgm_pkg.sv
// ============================================================================
// Module      : bgm_pkg
// Description : Shared types and constants for the bgm pipeline and its
//               streaming controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bgm_pkg;

    localparam int BGM_BITS            = 32;
    localparam int BGM_DEFAULT_LATENCY = 20;

    // Field order matches the concatenation order used to load the set.
    typedef struct packed {
        logic [BGM_BITS-1:0] sigma_a;
        logic [BGM_BITS-1:0] sigma_b;
        logic [BGM_BITS-1:0] sigma_c;
        logic [BGM_BITS-1:0] fn;
        logic [BGM_BITS-1:0] dw_x;
        logic [BGM_BITS-1:0] dw_y;
        logic [BGM_BITS-1:0] dw_z;
        logic [BGM_BITS-1:0] dt;
    } bgm_operands_t;

endpackage

`default_nettype wire

// File: rtl/bgm_result_fifo.sv
// ============================================================================
// Module      : bgm_result_fifo
// Description : First-word-fall-through result FIFO with registered storage;
//               simultaneous push and pop allowed at any occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bgm_result_fifo
    import bgm_pkg::*;
#(
    parameter int BITS  = BGM_BITS,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [BITS-1:0]          push_data_i,
    input  logic                     pop_i,
    output logic                     head_valid_o,
    output logic [BITS-1:0]          head_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] C_PTR_ONE = (AW+1)'(1);

    logic [BITS-1:0] mem_q [DEPTH];
    logic [AW:0]     wr_q, wr_d;
    logic [AW:0]     rd_q, rd_d;
    logic            w_empty;
    logic            w_full;

    // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
    assign w_empty = (wr_q == rd_q);
    assign w_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_i) begin
            wr_d = wr_q + C_PTR_ONE;
        end
        if (pop_i && !w_empty) begin
            rd_d = rd_q + C_PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (push_i) begin
                mem_q[wr_q[AW-1:0]] <= push_data_i;
            end
        end
    end

    assign head_valid_o = !w_empty;
    assign head_data_o  = mem_q[rd_q[AW-1:0]];
    assign count_o      = wr_q - rd_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && w_full && !pop_i));

endmodule

`default_nettype wire

// File: rtl/bgm_stream_ctrl.sv
// ============================================================================
// Module      : bgm_stream_ctrl
// Description : Credit-admitted streaming front/back end for the bgm pipeline.
//               Optional build macro BGM_CTRL_ZERO_IDLE_EN zeroes the operand
//               drive on idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bgm_stream_ctrl
    import bgm_pkg::*;
#(
    parameter int BITS    = BGM_BITS,
    parameter int LATENCY = BGM_DEFAULT_LATENCY,
    parameter int DEPTH   = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_sigma_a,
    input  logic [BITS-1:0] in_sigma_b,
    input  logic [BITS-1:0] in_sigma_c,
    input  logic [BITS-1:0] in_Fn,
    input  logic [BITS-1:0] in_dw_x,
    input  logic [BITS-1:0] in_dw_y,
    input  logic [BITS-1:0] in_dw_z,
    input  logic [BITS-1:0] in_dt,
    output logic [BITS-1:0] sigma_a,
    output logic [BITS-1:0] sigma_b,
    output logic [BITS-1:0] sigma_c,
    output logic [BITS-1:0] Fn,
    output logic [BITS-1:0] dw_x,
    output logic [BITS-1:0] dw_y,
    output logic [BITS-1:0] dw_z,
    output logic [BITS-1:0] dt,
    input  logic [BITS-1:0] Fn_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_data,
    output logic            busy
);

    localparam int          CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
    localparam logic [CW-1:0] C_CRED_ONE = CW'(1);

    logic [CW-1:0]      credits_q, credits_d;
    bgm_operands_t      ops_q, ops_d;
    logic               launch_q;
    logic [LATENCY-1:0] tok_q, tok_d;
    logic               w_issue;
    logic               w_pop;
    bgm_operands_t      w_ops_in;
    logic [CW-1:0]      w_count;

    assign in_ready = (credits_q != '0);
    assign w_issue  = in_valid && in_ready;
    assign w_pop    = out_valid && out_ready;
    assign w_ops_in = {in_sigma_a, in_sigma_b, in_sigma_c, in_Fn,
                       in_dw_x, in_dw_y, in_dw_z, in_dt};

    always_comb begin
        credits_d = credits_q;
        case ({w_issue, w_pop})
            2'b10:   credits_d = credits_q - C_CRED_ONE;
            2'b01:   credits_d = credits_q + C_CRED_ONE;
            default: credits_d = credits_q;
        endcase
    end

    always_comb begin
        ops_d = ops_q;
`ifdef BGM_CTRL_ZERO_IDLE_EN
        ops_d = '0;
`endif
        if (w_issue) begin
            ops_d = w_ops_in;
        end
    end

    // launch_q tags the operand registers; the LATENCY-stage token chain then
    // tracks the set through bgm until its Fn_out appears.
    if (LATENCY == 1) begin : g_tok_single
        assign tok_d = launch_q;
    end else begin : g_tok_shift
        assign tok_d = {tok_q[LATENCY-2:0], launch_q};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            credits_q <= C_DEPTH;
            ops_q     <= '0;
            launch_q  <= 1'b0;
            tok_q     <= '0;
        end else begin
            credits_q <= credits_d;
            ops_q     <= ops_d;
            launch_q  <= w_issue;
            tok_q     <= tok_d;
        end
    end

    assign sigma_a = ops_q.sigma_a;
    assign sigma_b = ops_q.sigma_b;
    assign sigma_c = ops_q.sigma_c;
    assign Fn      = ops_q.fn;
    assign dw_x    = ops_q.dw_x;
    assign dw_y    = ops_q.dw_y;
    assign dw_z    = ops_q.dw_z;
    assign dt      = ops_q.dt;

    bgm_result_fifo #(
        .BITS  (BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clock),
        .rst_n        (reset),
        .push_i       (tok_q[LATENCY-1]),
        .push_data_i  (Fn_out),
        .pop_i        (w_pop),
        .head_valid_o (out_valid),
        .head_data_o  (out_data),
        .count_o      (w_count)
    );

    assign busy = launch_q || (|tok_q) || (w_count != '0);

endmodule

`default_nettype wire

// File: tb/tb_bgm_stream_ctrl.sv
// ============================================================================
// Module      : tb_bgm_stream_ctrl
// Description : Directed self-checking bench for bgm_stream_ctrl with a
//               delay-line bgm stub (LATENCY=4, DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bgm_stream_ctrl;

    localparam int L = 4;
    localparam int D = 8;
    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_sigma_a = '0, in_sigma_b = '0, in_sigma_c = '0, in_Fn = '0;
    logic [W-1:0] in_dw_x = '0, in_dw_y = '0, in_dw_z = '0, in_dt = '0;
    logic [W-1:0] sigma_a, sigma_b, sigma_c, Fn, dw_x, dw_y, dw_z, dt;
    logic [W-1:0] Fn_out;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    bgm_stream_ctrl #(
        .BITS    (W),
        .LATENCY (L),
        .DEPTH   (D)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sigma_a (in_sigma_a),
        .in_sigma_b (in_sigma_b),
        .in_sigma_c (in_sigma_c),
        .in_Fn      (in_Fn),
        .in_dw_x    (in_dw_x),
        .in_dw_y    (in_dw_y),
        .in_dw_z    (in_dw_z),
        .in_dt      (in_dt),
        .sigma_a    (sigma_a),
        .sigma_b    (sigma_b),
        .sigma_c    (sigma_c),
        .Fn         (Fn),
        .dw_x       (dw_x),
        .dw_y       (dw_y),
        .dw_z       (dw_z),
        .dt         (dt),
        .Fn_out     (Fn_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    // bgm stub: Fn_out is Fn delayed by L register stages, never reset.
    logic [W-1:0] pipe [L];
    always @(posedge clock) begin
        pipe[0] <= Fn;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign Fn_out = pipe[L-1];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ops(input logic [W-1:0] v);
        in_Fn      = v;
        in_sigma_a = v ^ 32'hA5A5_0001;
        in_sigma_b = v + 32'd1;
        in_sigma_c = v + 32'd2;
        in_dw_x    = ~v;
        in_dw_y    = v ^ 32'h0F0F_0F0F;
        in_dw_z    = v + 32'h100;
        in_dt      = v ^ 32'h8000_0000;
    endtask

    // Reference model: queue of issued results with the edge after which each
    // becomes visible at the output (issue edge + L + 1).
    typedef struct {
        logic [W-1:0] data;
        int           due;
    } res_t;

    res_t          mq[$];
    logic [W-1:0]  got_q[$];
    logic [8*W-1:0] last_ops;
    logic [8*W-1:0] exp_ops;
    bit            m_iss, m_ov, m_pop, m_exp_ov;
    int            cyc;
    res_t          m_new;

    initial begin
        cyc      = 0;
        last_ops = '0;
        m_iss    = 1'b0;
        forever begin
            @(posedge clock);
            if (!reset) begin
                mq.delete();
                last_ops = '0;
                m_iss    = 1'b0;
            end else begin
                m_ov  = (mq.size() > 0) && (mq[0].due <= cyc);
                m_pop = m_ov && out_ready;
                m_iss = in_valid && (mq.size() < D);
                if (m_pop) begin
                    got_q.push_back(mq[0].data);
                    mq.delete(0);
                end
                if (m_iss) begin
                    m_new.data = in_Fn;
                    m_new.due  = cyc + 1 + L + 1;
                    mq.push_back(m_new);
                    last_ops = {in_sigma_a, in_sigma_b, in_sigma_c, in_Fn,
                                in_dw_x, in_dw_y, in_dw_z, in_dt};
                end
            end
            cyc++;
            @(negedge clock);
            if (reset) begin
                m_exp_ov = (mq.size() > 0) && (mq[0].due <= cyc);
`ifdef BGM_CTRL_ZERO_IDLE_EN
                exp_ops = m_iss ? last_ops : '0;
`else
                exp_ops = last_ops;
`endif
                chk("mon_in_ready", in_ready, mq.size() < D);
                chk("mon_out_valid", out_valid, m_exp_ov);
                if (m_exp_ov) chk("mon_out_data", out_data, mq[0].data);
                chk("mon_busy", busy, mq.size() != 0);
                chk("mon_operands", {sigma_a, sigma_b, sigma_c, Fn, dw_x, dw_y, dw_z, dt}, exp_ops);
            end
        end
    end

    int acc;

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_operands", {sigma_a, sigma_b, sigma_c, Fn, dw_x, dw_y, dw_z, dt}, 0);
        reset = 1'b1;
        tick();
        tick();

        // Single issue: result visible L+1 edges after the issue edge.
        set_ops(32'h3F80_0000);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        set_ops(32'h0);
        chk("t1_fn_drive", Fn, 32'h3F80_0000);
        chk("t1_busy", busy, 1);
        repeat (L) tick();
        chk("t1_not_yet", out_valid, 0);
        tick();
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 32'h3F80_0000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_drained", out_valid, 0);
        chk("t1_idle", busy, 0);

        // Back-to-back stream with the consumer always ready.
        got_q.delete();
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            set_ops(32'(i));
            in_valid = 1'b1;
            chk("t2_in_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        set_ops(32'h0);
        repeat (L + 3) tick();
        chk("t2_count", got_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            chk("t2_order", (i < got_q.size()) ? got_q[i] : 32'hxxxx_xxxx, 32'(i + 1));
        end
        chk("t2_idle", busy, 0);

        // Backpressure: exactly D sets admitted, then one credit per pop.
        out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            set_ops(32'h100 + 32'(k));
            in_valid = 1'b1;
            if (in_ready) acc++;
            tick();
        end
        chk("t3_accepted", acc, D);
        chk("t3_stalled", in_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t3_credit_back", in_ready, 1);
        set_ops(32'h200);
        tick();
        chk("t3_one_more", in_ready, 0);
        tick();
        chk("t3_still_stalled", in_ready, 0);

        // Full FIFO: pop alone, then pop with simultaneous issue.
        repeat (6) tick();
        chk("t4_head", out_valid, 1);
        set_ops(32'h300);
        out_ready = 1'b1;
        tick();
        chk("t4_after_pop", in_ready, 1);
        tick();
        chk("t4_issue_and_pop", in_ready, 1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_ops(32'h0);
        tick();
        chk("t4_credits_held", in_ready, 1);
        out_ready = 1'b1;
        repeat (20) tick();
        chk("t4_drained_busy", busy, 0);
        chk("t4_drained_valid", out_valid, 0);

        // Reset with two results queued and three sets in flight.
        out_ready = 1'b0;
        set_ops(32'h400);
        in_valid = 1'b1;
        tick();
        set_ops(32'h401);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk("t5_queued", out_valid, 1);
        for (int k = 2; k < 5; k++) begin
            set_ops(32'h400 + 32'(k));
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        set_ops(32'h0);
        reset = 1'b0;
        #1;
        chk("t5_in_ready", in_ready, 1);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_out_data", out_data, 0);
        chk("t5_busy", busy, 0);
        chk("t5_operands", {sigma_a, sigma_b, sigma_c, Fn, dw_x, dw_y, dw_z, dt}, 0);
        tick();
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        got_q.delete();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t5_no_stale", out_valid, 0);
        end
        chk("t5_nothing_popped", got_q.size(), 0);

        // Operation resumes cleanly after reset.
        set_ops(32'hCAFE_0001);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        set_ops(32'h0);
        repeat (L + 2) tick();
        chk("t6_count", got_q.size(), 1);
        chk("t6_data", (got_q.size() > 0) ? got_q[0] : 32'hxxxx_xxxx, 32'hCAFE_0001);
        chk("t6_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
